// File: rtl/serial_addsub_seq_if.sv
// Operand/result handshake plus the nibble-wide link to the external 4-bit adder.
interface serial_addsub_seq_if #(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned W = 4 * NIBBLES;

    logic         start;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         abort;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic [3:0]   nib_a;
    logic [3:0]   nib_b;
    logic         nib_cin;
    logic [3:0]   nib_sum;
    logic         nib_cout;
    logic         nib_c3;

    modport slave (
        input  start, op_sub, a, b, abort, nib_sum, nib_cout, nib_c3,
        output ready, busy, done, result, cout, ovf, nib_a, nib_b, nib_cin
    );

    modport master (
        output start, op_sub, a, b, abort, nib_sum, nib_cout, nib_c3,
        input  ready, busy, done, result, cout, ovf, nib_a, nib_b, nib_cin
    );
endinterface

// File: rtl/serial_addsub_seq.sv
// Nibble-serial adder/subtractor: walks the operands LSB nibble first through an
// external 4-bit adder, one slice per cycle, then publishes result/cout/ovf.
module serial_addsub_seq #(
    parameter int unsigned NIBBLES = 4
) (
    input logic                clk,
    input logic                rst_n,
    serial_addsub_seq_if.slave bus
);
    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NIBBLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            op_q, op_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    work_q, work_d;
    logic [W-1:0]    result_q, result_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic [3:0]      nib_a_sel, nib_b_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        work_d    = work_q;
        result_d  = result_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        nib_a_sel = '0;
        nib_b_sel = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx_q == IdxW'(i)) begin
                nib_a_sel = a_q[4*i +: 4];
                nib_b_sel = b_q[4*i +: 4] ^ {4{op_q}};
            end
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = bus.op_sub;
                    idx_d   = '0;
                    carry_d = bus.op_sub;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.abort) begin
                    idx_d   = '0;
                    state_d = StIdle;
                end else begin
                    for (int unsigned i = 0; i < NIBBLES; i++) begin
                        if (idx_q == IdxW'(i)) work_d[4*i +: 4] = bus.nib_sum;
                    end
                    carry_d = bus.nib_cout;
                    if (idx_q == IdxLast) begin
                        idx_d    = '0;
                        result_d = work_d;
                        cout_d   = bus.nib_cout;
                        ovf_d    = bus.nib_cout ^ bus.nib_c3;
                        state_d  = StDone;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign bus.ready   = (state_q == StIdle);
    assign bus.busy    = (state_q == StRun);
    assign bus.done    = (state_q == StDone);
    assign bus.result  = result_q;
    assign bus.cout    = cout_q;
    assign bus.ovf     = ovf_q;
    // Adder inputs are forced quiet whenever no slice is being processed.
    assign bus.nib_a   = (state_q == StRun) ? nib_a_sel : 4'h0;
    assign bus.nib_b   = (state_q == StRun) ? nib_b_sel : 4'h0;
    assign bus.nib_cin = (state_q == StRun) ? carry_q : 1'b0;
endmodule
